// File: rtl/pong_game_sequencer.sv
// Game-flow controller for the Pong datapath: sequences serve, rally, point and
// game-over phases once per game tick, gates ball/paddle updates and owns the score.
module pong_game_sequencer #(
  parameter int WIN_SCORE   = 15,
  parameter int SERVE_DELAY = 8,
  parameter int POINT_HOLD  = 16
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       paddle_run,
  output logic       serve_dir,
  output logic [7:0] score,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_PAUSED = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [5:0] SERVE_LOAD = 6'(SERVE_DELAY - 1);
  localparam logic [5:0] POINT_LOAD = 6'(POINT_HOLD - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     r_state;
  logic [5:0] r_timer;
  logic [3:0] r_score_opp;
  logic [3:0] r_score_ply;
  logic       r_serve_dir;
  logic       r_winner;
  logic       r_start_q;

  logic w_start_rise;
  logic w_ply_won;
  logic w_opp_won;

  assign w_start_rise = start & ~r_start_q;
  assign w_ply_won    = (r_score_ply == WIN);
  assign w_opp_won    = (r_score_opp == WIN);

  // NOTE: reset is tested inside the clocked block only, so it takes effect on a
  // clk_div edge; every register here uses non-blocking assignment.
  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_score_opp <= '0;
      r_score_ply <= '0;
      r_serve_dir <= 1'b1;
      r_winner    <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_start_q <= start;
      case (r_state)
        S_IDLE: begin
          if (w_start_rise) begin
            r_score_opp <= '0;
            r_score_ply <= '0;
            r_timer     <= SERVE_LOAD;
            r_state     <= S_SERVE;
          end
        end

        S_SERVE: begin
          if (r_timer == '0) r_state <= S_PLAY;
          else               r_timer <= r_timer - 6'd1;
        end

        S_PLAY: begin
          // A double miss is a dead ball: replay from the same server.
          if (miss_left && miss_right) begin
            r_timer <= POINT_LOAD;
            r_state <= S_POINT;
          end else if (miss_left) begin
            if (r_score_ply < WIN) r_score_ply <= r_score_ply + 4'd1;
            r_serve_dir <= 1'b0;
            r_timer     <= POINT_LOAD;
            r_state     <= S_POINT;
          end else if (miss_right) begin
            if (r_score_opp < WIN) r_score_opp <= r_score_opp + 4'd1;
            r_serve_dir <= 1'b1;
            r_timer     <= POINT_LOAD;
            r_state     <= S_POINT;
          end else if (pause) begin
            r_state <= S_PAUSED;
          end
        end

        S_POINT: begin
          if (r_timer == '0) begin
            if (w_ply_won || w_opp_won) begin
              r_winner <= w_ply_won;
              r_state  <= S_OVER;
            end else begin
              r_timer <= SERVE_LOAD;
              r_state <= S_SERVE;
            end
          end else begin
            r_timer <= r_timer - 6'd1;
          end
        end

        S_PAUSED: begin
          if (!pause) r_state <= S_PLAY;
        end

        S_OVER: begin
          // Edge-detected so a button held since the last rally cannot restart.
          if (w_start_rise) begin
            r_score_opp <= '0;
            r_score_ply <= '0;
            r_winner    <= 1'b0;
            r_serve_dir <= 1'b1;
            r_timer     <= SERVE_LOAD;
            r_state     <= S_SERVE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ball_run   = 1'b0;
    ball_reset = 1'b0;
    paddle_run = 1'b0;
    game_over  = 1'b0;
    case (r_state)
      S_IDLE:   ball_reset = 1'b1;
      S_SERVE: begin
        ball_reset = 1'b1;
        paddle_run = 1'b1;
      end
      S_PLAY: begin
        ball_run   = 1'b1;
        paddle_run = 1'b1;
      end
      S_POINT:  ball_reset = 1'b1;
      S_PAUSED: ;
      S_OVER: begin
        ball_reset = 1'b1;
        game_over  = 1'b1;
      end
      default:  ;
    endcase
  end

  assign serve_dir = r_serve_dir;
  assign score     = {r_score_opp, r_score_ply};
  assign winner    = r_winner;
  assign state     = r_state;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer (WIN_SCORE=3): a vector table walks a full
// game, then hand sequences cover an opponent win, mid-serve reset and start-through-reset.
module tb_pong_game_sequencer;

  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2,
                         POINT = 3'd3, PAUSED = 3'd4, OVER = 3'd5;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_run, ball_reset, paddle_run, serve_dir, game_over, winner;
  logic [7:0] score;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  pong_game_sequencer #(.WIN_SCORE(3), .SERVE_DELAY(8), .POINT_HOLD(16)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .start(start), .pause(pause),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_run(ball_run), .ball_reset(ball_reset), .paddle_run(paddle_run),
    .serve_dir(serve_dir), .score(score), .game_over(game_over),
    .winner(winner), .state(state)
  );

  always #5 clk_div = ~clk_div;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         n;
    logic       rst_n, start, pause, ml, mr;
    logic [2:0] st;
    logic [7:0] sc;
    logic       sdir, win;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int n, logic r, logic s, logic p, logic ml, logic mr,
                             logic [2:0] st, logic [7:0] sc, logic sdir, logic win);
    vec_t t;
    t.n = n; t.rst_n = r; t.start = s; t.pause = p; t.ml = ml; t.mr = mr;
    t.st = st; t.sc = sc; t.sdir = sdir; t.win = win;
    return t;
  endfunction

  // Expected {ball_run, ball_reset, paddle_run, game_over} for each phase.
  function automatic logic [3:0] ctrl_of(logic [2:0] s);
    case (s)
      IDLE:    return 4'b0100;
      SERVE:   return 4'b0110;
      PLAY:    return 4'b1010;
      POINT:   return 4'b0100;
      PAUSED:  return 4'b0000;
      OVER:    return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] pack_exp(logic [2:0] st, logic [7:0] sc, logic sdir, logic win);
    return 32'({st, sc, sdir, win, ctrl_of(st)});
  endfunction

  function automatic logic [31:0] pack_act();
    return 32'({state, score, serve_dir, winner, ball_run, ball_reset, paddle_run, game_over});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_div);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int left = budget;
    while (state !== target && left > 0) begin
      tick(1);
      left--;
    end
    check(name, 32'(state), 32'(target));
  endtask

  initial begin
    //        n  rst st pa ml mr  state   score  sdir win
    vecs.push_back(v( 2, 0, 0, 0, 0, 0, IDLE,   8'h00, 1, 0));
    vecs.push_back(v( 3, 1, 0, 0, 0, 0, IDLE,   8'h00, 1, 0));
    vecs.push_back(v( 1, 1, 1, 0, 0, 0, SERVE,  8'h00, 1, 0));
    vecs.push_back(v( 7, 1, 1, 0, 0, 0, SERVE,  8'h00, 1, 0));
    vecs.push_back(v( 1, 1, 1, 0, 0, 0, PLAY,   8'h00, 1, 0));
    vecs.push_back(v( 3, 1, 0, 0, 0, 0, PLAY,   8'h00, 1, 0));
    vecs.push_back(v( 1, 1, 0, 0, 1, 0, POINT,  8'h01, 0, 0));
    vecs.push_back(v(15, 1, 0, 0, 0, 0, POINT,  8'h01, 0, 0));
    vecs.push_back(v( 1, 1, 0, 0, 0, 0, SERVE,  8'h01, 0, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h01, 0, 0));
    vecs.push_back(v( 1, 1, 0, 0, 1, 1, POINT,  8'h01, 0, 0));
    vecs.push_back(v(16, 1, 0, 0, 0, 0, SERVE,  8'h01, 0, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h01, 0, 0));
    vecs.push_back(v( 1, 1, 0, 0, 0, 1, POINT,  8'h11, 1, 0));
    vecs.push_back(v(16, 1, 0, 0, 0, 0, SERVE,  8'h11, 1, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h11, 1, 0));
    vecs.push_back(v( 1, 1, 0, 1, 0, 0, PAUSED, 8'h11, 1, 0));
    vecs.push_back(v( 1, 1, 0, 1, 1, 0, PAUSED, 8'h11, 1, 0));
    vecs.push_back(v( 3, 1, 0, 1, 0, 0, PAUSED, 8'h11, 1, 0));
    vecs.push_back(v( 1, 1, 0, 0, 0, 0, PLAY,   8'h11, 1, 0));
    vecs.push_back(v( 1, 1, 0, 0, 1, 0, POINT,  8'h12, 0, 0));
    vecs.push_back(v(16, 1, 0, 0, 0, 0, SERVE,  8'h12, 0, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h12, 0, 0));
    vecs.push_back(v( 1, 1, 0, 0, 1, 0, POINT,  8'h13, 0, 0));
    vecs.push_back(v(15, 1, 0, 0, 0, 0, POINT,  8'h13, 0, 0));
    vecs.push_back(v( 1, 1, 1, 0, 0, 0, OVER,   8'h13, 0, 1));
    vecs.push_back(v( 3, 1, 1, 0, 0, 0, OVER,   8'h13, 0, 1));
    vecs.push_back(v( 1, 1, 0, 0, 0, 0, OVER,   8'h13, 0, 1));
    vecs.push_back(v( 1, 1, 1, 0, 0, 0, SERVE,  8'h00, 1, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h00, 1, 0));
    vecs.push_back(v( 1, 1, 0, 0, 0, 1, POINT,  8'h10, 1, 0));
    vecs.push_back(v(16, 1, 0, 0, 0, 0, SERVE,  8'h10, 1, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h10, 1, 0));
    vecs.push_back(v( 1, 1, 0, 0, 0, 1, POINT,  8'h20, 1, 0));
    vecs.push_back(v(16, 1, 0, 0, 0, 0, SERVE,  8'h20, 1, 0));
    vecs.push_back(v( 8, 1, 0, 0, 0, 0, PLAY,   8'h20, 1, 0));
    vecs.push_back(v( 1, 1, 0, 0, 1, 0, POINT,  8'h21, 0, 0));
    vecs.push_back(v( 5, 1, 0, 0, 0, 0, POINT,  8'h21, 0, 0));
    vecs.push_back(v( 1, 0, 0, 0, 0, 0, IDLE,   8'h00, 1, 0));
    vecs.push_back(v( 2, 1, 0, 0, 0, 0, IDLE,   8'h00, 1, 0));

    foreach (vecs[i]) begin
      rst_n      = vecs[i].rst_n;
      start      = vecs[i].start;
      pause      = vecs[i].pause;
      miss_left  = vecs[i].ml;
      miss_right = vecs[i].mr;
      tick(vecs[i].n);
      check($sformatf("vec%0d", i), pack_act(),
            pack_exp(vecs[i].st, vecs[i].sc, vecs[i].sdir, vecs[i].win));
    end

    // Opponent wins 3-0; each point waits for the rally with a bounded budget.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("opp_serve", pack_act(), pack_exp(SERVE, 8'h00, 1, 0));
    for (int k = 0; k < 3; k++) begin
      wait_state(PLAY, 40, $sformatf("opp_rally%0d", k));
      miss_right = 1'b1;
      tick(1);
      miss_right = 1'b0;
    end
    check("opp_last_point", pack_act(), pack_exp(POINT, 8'h30, 1, 0));
    wait_state(OVER, 40, "opp_reach_over");
    check("opp_over", pack_act(), pack_exp(OVER, 8'h30, 1, 0));

    // Restart from OVER, then reset in the middle of the serve hold.
    start = 1'b1;
    tick(1);
    check("restart_serve", pack_act(), pack_exp(SERVE, 8'h00, 1, 0));
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("reset_mid_serve", pack_act(), pack_exp(IDLE, 8'h00, 1, 0));

    // start stays high through reset; the cleared edge detector sees a fresh press.
    rst_n = 1'b1;
    tick(1);
    check("start_through_reset", pack_act(), pack_exp(SERVE, 8'h00, 1, 0));
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
